glm_load: RTL and testbench

Upstream companion of the GLM writeback stage. Executes one load instruction: fetches a contiguous run of cache lines from DRAM through the DMA read engine and writes them, in order, into one of two on-chip FIFO/BRAM regions (REGION0 or REGION1). Those regions are later drained by the compute pipeline and the writeback stage. Sits between the instruction dispatcher and the DMA read port, next to the writeback stage.

---
 rtl/glm_load_pkg.sv | 36 +++
 rtl/glm_load_write_region.sv | 52 +++++
 rtl/glm_load.sv | 125 ++++++++++++
 tb/tb_glm_load.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glm_load_pkg.sv
// Shared types and field positions for the GLM load stage.
// Cache-line addresses are DRAM line indices; regs[5] packs the region select and the region base.
package glm_load_pkg;
  localparam int CLADDR_WIDTH = 58;
  localparam int CLDATA_WIDTH = 512;
  localparam int NUM_REGS     = 6;
  localparam int DMA_NUM_REGS = 6;

  typedef logic [CLADDR_WIDTH-1:0] t_claddr;
  typedef logic [31:0]             t_dma_reg;

  typedef enum logic [2:0] {
    IDLE,
    PREPROCESS,
    TRIGGER,
    READ,
    DONE
  } t_loadstate;

  localparam int REG_BASE        = 3;
  localparam int REG_LEN         = 4;
  localparam int REG_CFG         = 5;
  localparam int DMA_REG_LEN     = 4;
  localparam int BASE_SEL_BIT    = 31;
  localparam int REGION_SEL_LSB  = 0;
  localparam int REGION_SEL_MSB  = 3;
  localparam int REGION_BASE_LSB = 16;

  // regs[3]: bit31 picks out_addr over in_addr, the low 31 bits are a line offset.
  function automatic t_claddr dram_base(input t_claddr in_a, input t_claddr out_a,
                                        input t_dma_reg r);
    t_claddr b;
    b = r[BASE_SEL_BIT] ? out_a : in_a;
    return b + {{(CLADDR_WIDTH-31){1'b0}}, r[30:0]};
  endfunction
endpackage

// File: rtl/glm_load_write_region.sv
// Registers one incoming DMA line per cycle and writes it to the selected region
// at base + running count; the count wraps modulo 2^ADDR_WIDTH.
module glm_load_write_region
  import glm_load_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [CLDATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]   base,
  input  logic                    sel,
  output logic                    region0_we,
  output logic [ADDR_WIDTH-1:0]   region0_waddr,
  output logic [CLDATA_WIDTH-1:0] region0_wdata,
  output logic                    region1_we,
  output logic [ADDR_WIDTH-1:0]   region1_waddr,
  output logic [CLDATA_WIDTH-1:0] region1_wdata
);
  logic                    we_r;
  logic [ADDR_WIDTH-1:0]   waddr_r;
  logic [ADDR_WIDTH-1:0]   wcnt;
  logic [CLDATA_WIDTH-1:0] wdata_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= '0;
      wcnt    <= '0;
    end else begin
      we_r <= in_valid;
      if (clear) begin
        wcnt <= '0;
      end else if (in_valid) begin
        waddr_r <= base + wcnt;
        wdata_r <= in_data;
        wcnt    <= wcnt + 1'b1;
      end
    end
  end

  // sel only changes while idle, so gating the shared write register is safe.
  assign region0_we    = we_r & ~sel;
  assign region1_we    = we_r & sel;
  assign region0_waddr = waddr_r;
  assign region1_waddr = waddr_r;
  assign region0_wdata = wdata_r;
  assign region1_wdata = wdata_r;
endmodule

// File: rtl/glm_load.sv
// GLM load stage: computes the DRAM line address, kicks the DMA read engine and
// streams the returned lines in order into REGION0 or REGION1.
module glm_load
  import glm_load_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                op_start,
  output logic                                op_done,
  input  logic [NUM_REGS-1:0][31:0]           regs,
  input  logic [CLADDR_WIDTH-1:0]             in_addr,
  input  logic [CLADDR_WIDTH-1:0]             out_addr,
  output logic                                dma_start,
  output logic [CLADDR_WIDTH-1:0]             dma_addr,
  output logic [DMA_NUM_REGS-1:0][31:0]       dma_regs,
  input  logic                                dma_idle,
  input  logic                                dma_active,
  input  logic                                dma_done,
  input  logic                                dma_rvalid,
  input  logic [CLDATA_WIDTH-1:0]             dma_rdata,
  output logic                                dma_almostfull,
  output logic                                region0_we,
  output logic [ADDR_WIDTH-1:0]               region0_waddr,
  output logic [CLDATA_WIDTH-1:0]             region0_wdata,
  output logic                                region1_we,
  output logic [ADDR_WIDTH-1:0]               region1_waddr,
  output logic [CLDATA_WIDTH-1:0]             region1_wdata
);
  t_loadstate            state;
  t_claddr               dram_addr;
  logic [2:0][31:0]      offs;
  logic [1:0]            pp_cnt;
  logic [31:0]           len;
  logic [31:0]           num_recv;
  logic [ADDR_WIDTH-1:0] region_base;
  logic                  region_sel;
  logic                  finish;
  logic                  wr_valid;
  logic                  op_accept;
  logic                  unused_ok;

  assign op_accept = (state == IDLE) && op_start;
  // Once the last line (or dma_done) is seen, later beats are dropped.
  assign wr_valid  = (state == READ) && !finish && dma_rvalid;
  assign dma_almostfull = (state != READ);
  assign unused_ok = ^{dma_active, regs[REG_CFG][REGION_BASE_LSB-1:REGION_SEL_MSB+1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_done     <= 1'b0;
      dma_start   <= 1'b0;
      dma_addr    <= '0;
      dma_regs    <= '0;
      dram_addr   <= '0;
      offs        <= '0;
      pp_cnt      <= '0;
      len         <= '0;
      num_recv    <= '0;
      region_base <= '0;
      region_sel  <= 1'b0;
      finish      <= 1'b0;
    end else begin
      op_done   <= 1'b0;
      dma_start <= 1'b0;
      case (state)
        IDLE: if (op_start) begin
          offs        <= regs[2:0];
          len         <= regs[REG_LEN];
          region_base <= regs[REG_CFG][REGION_BASE_LSB +: ADDR_WIDTH];
          region_sel  <= (regs[REG_CFG][REGION_SEL_MSB:REGION_SEL_LSB] != '0);
          dram_addr   <= dram_base(in_addr, out_addr, regs[REG_BASE]);
          pp_cnt      <= '0;
          num_recv    <= '0;
          finish      <= 1'b0;
          state       <= (regs[REG_LEN] == '0) ? DONE : PREPROCESS;
        end
        PREPROCESS: begin
          dram_addr <= dram_addr + {{(CLADDR_WIDTH-32){1'b0}}, offs[pp_cnt]};
          pp_cnt    <= pp_cnt + 2'd1;
          if (pp_cnt == 2'd2) state <= TRIGGER;
        end
        TRIGGER: if (dma_idle) begin
          dma_start             <= 1'b1;
          dma_addr              <= dram_addr;
          dma_regs              <= '0;
          dma_regs[DMA_REG_LEN] <= len;
          state                 <= READ;
        end
        READ: begin
          // finish is set on the receive cycle; the write lands the next cycle, then DONE.
          if (finish) begin
            state <= DONE;
          end else begin
            if (dma_rvalid) num_recv <= num_recv + 32'd1;
            if ((dma_rvalid && (num_recv == len - 32'd1)) || dma_done) finish <= 1'b1;
          end
        end
        DONE: begin
          op_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  glm_load_write_region #(.ADDR_WIDTH(ADDR_WIDTH)) u_write_region (
    .clk           (clk),
    .reset         (reset),
    .clear         (op_accept),
    .in_valid      (wr_valid),
    .in_data       (dma_rdata),
    .base          (region_base),
    .sel           (region_sel),
    .region0_we    (region0_we),
    .region0_waddr (region0_waddr),
    .region0_wdata (region0_wdata),
    .region1_we    (region1_we),
    .region1_waddr (region1_waddr),
    .region1_wdata (region1_wdata)
  );
endmodule

// File: tb/tb_glm_load.sv
// Directed bench for glm_load: DMA read engine stub, region write monitor and
// per-scenario checks against hand-computed addresses and cycle offsets.
module tb_glm_load;
  import glm_load_pkg::*;
  localparam int AW = 16;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        op_start = 1'b0;
  logic                        op_done;
  logic [NUM_REGS-1:0][31:0]   regs = '0;
  logic [CLADDR_WIDTH-1:0]     in_addr = '0, out_addr = '0;
  logic                        dma_start;
  logic [CLADDR_WIDTH-1:0]     dma_addr;
  logic [DMA_NUM_REGS-1:0][31:0] dma_regs;
  logic                        dma_idle = 1'b1, dma_active = 1'b0, dma_done = 1'b0, dma_rvalid = 1'b0;
  logic [CLDATA_WIDTH-1:0]     dma_rdata = '0;
  logic                        dma_almostfull;
  logic                        region0_we, region1_we;
  logic [AW-1:0]               region0_waddr, region1_waddr;
  logic [CLDATA_WIDTH-1:0]     region0_wdata, region1_wdata;

  glm_load #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_done(op_done), .regs(regs),
    .in_addr(in_addr), .out_addr(out_addr), .dma_start(dma_start), .dma_addr(dma_addr),
    .dma_regs(dma_regs), .dma_idle(dma_idle), .dma_active(dma_active), .dma_done(dma_done),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_almostfull(dma_almostfull),
    .region0_we(region0_we), .region0_waddr(region0_waddr), .region0_wdata(region0_wdata),
    .region1_we(region1_we), .region1_waddr(region1_waddr), .region1_wdata(region1_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, errors = 0;

  // Monitor: records every region write and control pulse with its cycle number.
  int                      w0_cyc[$], w1_cyc[$];
  logic [AW-1:0]           w0_addr[$], w1_addr[$];
  logic [CLDATA_WIDTH-1:0] w0_data[$], w1_data[$];
  int                      n_start = 0, start_cyc = -1, n_done = 0, done_cyc = -1;
  logic [CLADDR_WIDTH-1:0] start_addr;
  logic [DMA_NUM_REGS-1:0][31:0] start_regs;

  always @(negedge clk) begin
    if (region0_we) begin w0_cyc.push_back(cyc); w0_addr.push_back(region0_waddr); w0_data.push_back(region0_wdata); end
    if (region1_we) begin w1_cyc.push_back(cyc); w1_addr.push_back(region1_waddr); w1_data.push_back(region1_wdata); end
    if (dma_start) begin n_start++; start_cyc = cyc; start_addr = dma_addr; start_regs = dma_regs; end
    if (op_done) begin n_done++; done_cyc = cyc; end
  end

  function automatic logic [CLDATA_WIDTH-1:0] line(input int k);
    return {16{32'hC0DE_0000 + 32'(k)}};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    w0_cyc.delete(); w0_addr.delete(); w0_data.delete();
    w1_cyc.delete(); w1_addr.delete(); w1_data.delete();
    n_start = 0; start_cyc = -1; n_done = 0; done_cyc = -1;
  endtask

  task automatic pulse_start(output int t);
    t = cyc;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 60 && n_start == 0; i++) tick();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && n_done == 0; i++) tick();
    repeat (3) tick();
  endtask

  // rvalid beat i lands in cycle first_c + i*(gap+1); dma_done optionally rides on the last beat.
  task automatic feed(input int n, input int gap, input int tag, input bit done_last, output int first_c);
    first_c = cyc;
    for (int i = 0; i < n; i++) begin
      dma_rvalid = 1'b1;
      dma_rdata  = line(tag + i);
      dma_done   = done_last && (i == n - 1);
      tick();
      dma_rvalid = 1'b0;
      dma_done   = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    tests++;
    if ({op_done, dma_start, region0_we, region1_we, dma_almostfull} !== 5'b00001) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00001", {op_done, dma_start, region0_we, region1_we, dma_almostfull});
    end
    tests++;
    if (dma_addr !== '0 || dma_regs !== '0 || region0_waddr !== '0 || region1_waddr !== '0) begin
      errors++; $display("FAIL reset_regs: addr %h regs %h waddr %h/%h want all 0", dma_addr, dma_regs, region0_waddr, region1_waddr);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_len0();
    int t;
    clear_mon();
    regs = '0;
    pulse_start(t);
    wait_done();
    tests++;
    if (n_done !== 1 || done_cyc !== t + 2) begin
      errors++; $display("FAIL len0_done: count %0d at %0d, want 1 at %0d", n_done, done_cyc, t + 2);
    end
    tests++;
    if (n_start !== 0 || w0_addr.size() + w1_addr.size() !== 0) begin
      errors++; $display("FAIL len0_quiet: starts %0d writes %0d, want 0/0", n_start, w0_addr.size() + w1_addr.size());
    end
  endtask

  task automatic test_basic();
    int t, fc, bad;
    logic [DMA_NUM_REGS-1:0][31:0] exp_regs;
    clear_mon();
    in_addr = 58'h1000; out_addr = 58'h5000;
    regs = '0;
    regs[0] = 32'd1; regs[1] = 32'd2; regs[2] = 32'd3;
    regs[3] = 32'h0000_0010; regs[4] = 32'd4; regs[5] = {16'h0020, 16'h0000};
    pulse_start(t);
    op_start = 1'b1;            // arrives in PREPROCESS and must be ignored
    tick();
    op_start = 1'b0;
    wait_start();
    exp_regs = '0; exp_regs[4] = 32'd4;
    tests++;
    if (start_cyc !== t + 5 || start_addr !== 58'h1016) begin
      errors++; $display("FAIL basic_start: cyc %0d addr %h, want %0d addr 1016", start_cyc, start_addr, t + 5);
    end
    tests++;
    if (start_regs !== exp_regs) begin
      errors++; $display("FAIL basic_dmaregs: got %h want %h", start_regs, exp_regs);
    end
    feed(4, 1, 16, 1'b0, fc);
    wait_done();
    tests++;
    if (w0_addr.size() !== 4 || w1_addr.size() !== 0) begin
      errors++; $display("FAIL basic_count: r0 %0d r1 %0d, want 4/0", w0_addr.size(), w1_addr.size());
    end
    bad = 0;
    for (int i = 0; i < w0_addr.size(); i++)
      if (w0_addr[i] !== AW'(16'h20 + i) || w0_data[i] !== line(16 + i) || w0_cyc[i] !== fc + 2 * i + 1) bad++;
    tests++;
    if (bad != 0) begin
      errors++; $display("FAIL basic_writes: %0d bad writes, want 0 (addr 20..23, rvalid cycle+1)", bad);
    end
    tests++;
    if (n_done !== 1 || done_cyc !== fc + 2 * 3 + 1 + 2 || n_start !== 1) begin
      errors++; $display("FAIL basic_done: done %0d at %0d starts %0d, want 1 at %0d starts 1", n_done, done_cyc, n_start, fc + 9);
    end
  endtask

  task automatic test_wrap();
    int t, fc, bad;
    clear_mon();
    in_addr = 58'h2000; out_addr = 58'h3000;
    regs = '0;
    regs[0] = 32'h10; regs[1] = 32'h20; regs[2] = 32'h40;
    regs[3] = 32'h8000_0005; regs[4] = 32'd8; regs[5] = {16'hFFFE, 16'h0001};
    pulse_start(t);
    wait_start();
    tests++;
    if (start_addr !== 58'h3075) begin
      errors++; $display("FAIL wrap_addr: got %h want 3075", start_addr);
    end
    feed(8, 0, 64, 1'b0, fc);
    wait_done();
    bad = 0;
    for (int i = 0; i < w1_addr.size(); i++)
      if (w1_addr[i] !== AW'(32'hFFFE + i) || w1_data[i] !== line(64 + i) || w1_cyc[i] !== fc + i + 1) bad++;
    tests++;
    if (w1_addr.size() !== 8 || bad != 0 || w0_addr.size() !== 0) begin
      errors++; $display("FAIL wrap_writes: r1 %0d (%0d bad) r0 %0d, want 8 (0 bad) 0", w1_addr.size(), bad, w0_addr.size());
    end
    tests++;
    if (n_done !== 1 || done_cyc !== fc + 7 + 1 + 2) begin
      errors++; $display("FAIL wrap_done: %0d at %0d, want 1 at %0d", n_done, done_cyc, fc + 10);
    end
  endtask

  task automatic test_idle_wait();
    int t, ic, fc, bad;
    clear_mon();
    dma_idle = 1'b0;
    in_addr = 58'h40;
    regs = '0; regs[4] = 32'd2; regs[5] = {16'h0100, 16'h0000};
    pulse_start(t);
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      if (n_start != 0 || dma_almostfull !== 1'b1) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_hold: %0d cycles with start or almostfull low, want 0", bad);
    end
    ic = cyc;
    dma_idle = 1'b1;
    wait_start();
    tests++;
    if (start_cyc !== ic + 1 || dma_almostfull !== 1'b0) begin
      errors++; $display("FAIL idle_release: start %0d almostfull %b, want %0d and 0", start_cyc, dma_almostfull, ic + 1);
    end
    feed(2, 0, 128, 1'b0, fc);
    wait_done();
    tests++;
    if (n_done !== 1 || w0_addr.size() !== 2 || dma_almostfull !== 1'b1) begin
      errors++; $display("FAIL idle_finish: done %0d writes %0d almostfull %b, want 1/2/1", n_done, w0_addr.size(), dma_almostfull);
    end
  endtask

  task automatic test_done_early();
    int t, fc;
    clear_mon();
    in_addr = 58'h100;
    regs = '0; regs[4] = 32'd16; regs[5] = {16'h0010, 16'h0001};
    pulse_start(t);
    wait_start();
    feed(10, 0, 200, 1'b1, fc);
    wait_done();
    tests++;
    if (w1_addr.size() !== 10 || w1_addr[9] !== 16'h0019 || w1_data[9] !== line(209) || w1_cyc[9] !== fc + 10) begin
      errors++; $display("FAIL early_writes: %0d writes, want 10 ending at 0019 in cycle %0d", w1_addr.size(), fc + 10);
    end
    tests++;
    if (n_done !== 1 || done_cyc !== fc + 12) begin
      errors++; $display("FAIL early_done: %0d at %0d, want 1 at %0d", n_done, done_cyc, fc + 12);
    end
  endtask

  task automatic test_reset_mid();
    int t, fc;
    clear_mon();
    in_addr = 58'h300;
    regs = '0; regs[4] = 32'd8; regs[5] = {16'h0200, 16'h0000};
    pulse_start(t);
    wait_start();
    feed(3, 0, 300, 1'b0, fc);
    reset = 1'b0;
    #1;
    tests++;
    if ({op_done, dma_start, region0_we, region1_we, dma_almostfull} !== 5'b00001 ||
        region0_waddr !== '0 || dma_addr !== '0 || dma_regs !== '0) begin
      errors++; $display("FAIL midreset_async: ctrl %b waddr %h addr %h, want 00001/0/0",
                         {op_done, dma_start, region0_we, region1_we, dma_almostfull}, region0_waddr, dma_addr);
    end
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    tests++;
    if (n_done !== 0) begin
      errors++; $display("FAIL midreset_nodone: op_done count %0d want 0", n_done);
    end
    clear_mon();
    in_addr = 58'h80;
    regs = '0; regs[4] = 32'd2; regs[5] = {16'h0030, 16'h0001};
    pulse_start(t);
    wait_start();
    tests++;
    if (start_cyc !== t + 5 || start_addr !== 58'h80) begin
      errors++; $display("FAIL midreset_restart: start %0d addr %h, want %0d addr 80", start_cyc, start_addr, t + 5);
    end
    feed(2, 0, 400, 1'b0, fc);
    wait_done();
    tests++;
    if (w1_addr.size() !== 2 || w1_addr[0] !== 16'h0030 || w1_addr[1] !== 16'h0031 || n_done !== 1) begin
      errors++; $display("FAIL midreset_rerun: %0d writes done %0d, want 2 at 0030/0031 done 1", w1_addr.size(), n_done);
    end
  endtask

  initial begin
    test_reset();
    test_len0();
    test_basic();
    test_wrap();
    test_idle_wait();
    test_done_early();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
